pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
Fetch-side front end of the RAT MCU, directly upstream of the program ROM. Owns the 10-bit program counter, drives the ROM address, and sequences the INIT/FETCH/EXEC/INTR cycle. It accounts for the ROM's one-cycle registered read latency, so the downstream decoder sees a valid instruction word only in EXEC.

Parameters:
ADDR_W, 10, program counter / ROM address width (1024 words)
INTR_VEC, 10'h3FF, interrupt service vector address
RESET_VEC, 10'h000, program counter value after reset

Ports:
CLK  in  1  system clock, single domain
RST  in  1  reset; synchronous, active-high
PC_LD  in  1  decoder request to load PC, honoured only in EXEC
PC_MUX_SEL  in  2  load source: 0 = FROM_IMMED, 1 = FROM_STACK, 2 = INTR_VEC, 3 = reserved
FROM_IMMED  in  10  branch/call target (IR[12:3])
FROM_STACK  in  10  return address popped by RET/RETIE
INTR  in  1  external interrupt request (level or pulse)
INT_EN  in  1  interrupt-enable flag from the flag unit
ADDR  out  10  ROM address; always equals the PC register
PC_COUNT  out  10  current PC, for CALL push and debug
IR_VALID  out  1  high only in EXEC; ROM IR output is valid
INTR_ACK  out  1  one-cycle pulse in the INTR state
RET_ADDR  out  10  PC value to push on interrupt entry; valid while INTR_ACK is high

Behaviour:
- All state updates occur on the rising edge of CLK. RST is sampled only at the clock edge.
- Reset values: state = INIT, PC = RESET_VEC, pending = 0, IR_VALID = 0, INTR_ACK = 0, RET_ADDR = 0.
- States: INIT, FETCH, EXEC, INTR.
- INIT: lasts one cycle, then moves to FETCH. The PC holds its value.
- FETCH:
  - ADDR = PC, and the ROM latches rom[PC] at the end of this cycle.
  - PC <= PC + 1, modulo 2^ADDR_W, so 10'h3FF wraps to 10'h000.
  - Next state is EXEC.
- EXEC:
  - IR_VALID = 1.
  - If PC_LD is high and PC_MUX_SEL is 0, 1 or 2, PC <= the selected source. PC_MUX_SEL = 3 leaves the PC unchanged.
  - Without PC_LD, the PC holds its value, which is the already-incremented address.
  - Next state is INTR if (pending | INTR) & INT_EN; otherwise FETCH.
- INTR:
  - INTR_ACK = 1.
  - RET_ADDR <= the PC value as left by EXEC, meaning any EXEC load has already been applied.
  - PC <= INTR_VEC and pending <= 0.
  - Next state is FETCH.
- Pending latch:
  - Set on any cycle where INTR is high, in every state except INTR.
  - Cleared on entering INTR or on RST.
  - While INT_EN is low, pending holds and is serviced at the first EXEC end where INT_EN is high.
- PC_LD outside EXEC is ignored.
- An interrupt arriving in the same cycle as a branch (PC_LD in EXEC) is serviced after the branch: RET_ADDR is the branch target.
- RST asserted in any state returns the block to INIT at the next edge. RST has priority over all other inputs, and an in-flight load or interrupt is discarded.
- Throughput: without interrupts, each instruction takes 2 cycles (FETCH + EXEC). Interrupt entry adds 1 cycle.

Decomposition:
- Shared package rat_pkg holds:
  - the state enum {ST_INIT, ST_FETCH, ST_EXEC, ST_INTR}
  - PC_MUX_SEL encodings (PCSEL_IMMED, PCSEL_STACK, PCSEL_INTR)
  - INTR_VEC and RESET_VEC constants
- One sub-module is natural: program_counter.
  - Contains the register, the next-PC mux, increment and load logic.
  - Inputs: CLK, RST, LD, INC, SEL, DIN_IMMED, DIN_STACK.
  - The FSM and pending latch stay in pc_fetch_ctrl.

Test Plan:
- Reset then free-run for 6 cycles with no PC_LD → state sequence INIT, FETCH, EXEC, FETCH, EXEC; ADDR shows 0 in the first FETCH and 1 in the second; IR_VALID is high only in EXEC cycles.
- In EXEC, PC_LD = 1, PC_MUX_SEL = 0, FROM_IMMED = 10'h0A5 → next FETCH has ADDR = 10'h0A5, and the following FETCH has ADDR = 10'h0A6.
- Force PC to 10'h3FF via PC_MUX_SEL = 2, then run one FETCH → PC wraps to 10'h000 in EXEC. Separately, PC_MUX_SEL = 3 with PC_LD = 1 → PC unchanged.
- One-cycle INTR pulse while INT_EN = 0, then raise INT_EN two instructions later → INTR entered at the end of that EXEC. INTR_ACK is high for exactly 1 cycle, RET_ADDR = the incremented PC, and the next FETCH has ADDR = 10'h3FF.
- INTR during an EXEC that branches to 10'h040 via FROM_STACK → RET_ADDR = 10'h040 and the next FETCH address is 10'h3FF.
- Assert RST during EXEC with PC_LD = 1 and pending = 1 → at the next edge state = INIT, PC = 0, pending = 0, and no INTR_ACK occurs afterwards.

Source files
------------

// File: rtl/rat_pkg.sv
// Shared types and constants for the RAT MCU fetch front end.
package rat_pkg;

    localparam int ADDR_W = 10;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_INTR  = 2'd3
    } state_t;

    // PC_MUX_SEL encodings; value 3 is reserved and leaves the PC unchanged.
    localparam logic [1:0] PCSEL_IMMED = 2'd0;
    localparam logic [1:0] PCSEL_STACK = 2'd1;
    localparam logic [1:0] PCSEL_INTR  = 2'd2;

    localparam logic [ADDR_W-1:0] INTR_VEC  = 10'h3FF;
    localparam logic [ADDR_W-1:0] RESET_VEC = 10'h000;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Decoder/ROM-facing bus of the fetch controller, plus FSM state for observation.
interface pc_fetch_ctrl_if
    import rat_pkg::*;
#(
    parameter int ADDR_W = rat_pkg::ADDR_W
);
    logic              PC_LD;
    logic [1:0]        PC_MUX_SEL;
    logic [ADDR_W-1:0] FROM_IMMED;
    logic [ADDR_W-1:0] FROM_STACK;
    logic              INTR;
    logic              INT_EN;
    logic [ADDR_W-1:0] ADDR;
    logic [ADDR_W-1:0] PC_COUNT;
    logic              IR_VALID;
    logic              INTR_ACK;
    logic [ADDR_W-1:0] RET_ADDR;
    state_t            STATE;

    // No backpressure exists: IR_VALID qualifies the ROM word for exactly the
    // EXEC cycle, and RET_ADDR is meaningful only while INTR_ACK is high.
    modport master (
        output PC_LD, PC_MUX_SEL, FROM_IMMED, FROM_STACK, INTR, INT_EN,
        input  ADDR, PC_COUNT, IR_VALID, INTR_ACK, RET_ADDR, STATE
    );

    modport slave (
        input  PC_LD, PC_MUX_SEL, FROM_IMMED, FROM_STACK, INTR, INT_EN,
        output ADDR, PC_COUNT, IR_VALID, INTR_ACK, RET_ADDR, STATE
    );

endinterface

// File: rtl/pc_fetch_ctrl_program_counter.sv
// Program counter register with increment and source-selected load.
module program_counter
    import rat_pkg::*;
#(
    parameter int                ADDR_W    = rat_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] INTR_VEC  = rat_pkg::INTR_VEC,
    parameter logic [ADDR_W-1:0] RESET_VEC = rat_pkg::RESET_VEC
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              LD,
    input  logic              INC,
    input  logic [1:0]        SEL,
    input  logic [ADDR_W-1:0] DIN_IMMED,
    input  logic [ADDR_W-1:0] DIN_STACK,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] PC_NEXT
);

    // Load wins over increment; the two are never requested together by the FSM.
    always_comb begin
        PC_NEXT = PC;
        if (LD) begin
            case (SEL)
                PCSEL_IMMED: PC_NEXT = DIN_IMMED;
                PCSEL_STACK: PC_NEXT = DIN_STACK;
                PCSEL_INTR:  PC_NEXT = INTR_VEC;
                default:     PC_NEXT = PC;
            endcase
        end else if (INC) begin
            PC_NEXT = PC + ADDR_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            PC <= RESET_VEC;
        end else begin
            PC <= PC_NEXT;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// RAT MCU fetch sequencer: INIT/FETCH/EXEC/INTR FSM, interrupt pending latch and PC.
module pc_fetch_ctrl
    import rat_pkg::*;
#(
    parameter int                ADDR_W    = rat_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] INTR_VEC  = rat_pkg::INTR_VEC,
    parameter logic [ADDR_W-1:0] RESET_VEC = rat_pkg::RESET_VEC
) (
    input  logic            CLK,
    input  logic            RST,
    pc_fetch_ctrl_if.slave  bus
);

    state_t            state;
    state_t            state_nx;
    logic              pending;
    logic              pending_nx;
    logic              take_intr;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] ret_addr;
    logic              pc_ld;
    logic              pc_inc;
    logic [1:0]        pc_sel;

    assign take_intr = (state == ST_EXEC) && ((pending || bus.INTR) && bus.INT_EN);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_INIT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_INIT:  state_nx = ST_FETCH;
            ST_FETCH: state_nx = ST_EXEC;
            ST_EXEC:  state_nx = take_intr ? ST_INTR : ST_FETCH;
            ST_INTR:  state_nx = ST_FETCH;
            default:  state_nx = ST_INIT;
        endcase
    end

    always_comb begin
        bus.IR_VALID = (state == ST_EXEC);
        bus.INTR_ACK = (state == ST_INTR);
        pc_inc       = (state == ST_FETCH);
        pc_ld        = ((state == ST_EXEC) && bus.PC_LD) || (state == ST_INTR);
        pc_sel       = (state == ST_INTR) ? PCSEL_INTR : bus.PC_MUX_SEL;
    end

    // Requests seen while already in INTR are absorbed by that entry.
    always_comb begin
        pending_nx = pending;
        if (state == ST_INTR || take_intr) begin
            pending_nx = 1'b0;
        end else if (bus.INTR) begin
            pending_nx = 1'b1;
        end
    end

    // Captured on entry so RET_ADDR is already valid during the INTR cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pending  <= 1'b0;
            ret_addr <= '0;
        end else begin
            pending <= pending_nx;
            if (take_intr) begin
                ret_addr <= pc_next;
            end
        end
    end

    program_counter #(
        .ADDR_W    (ADDR_W),
        .INTR_VEC  (INTR_VEC),
        .RESET_VEC (RESET_VEC)
    ) u_pc (
        .CLK       (CLK),
        .RST       (RST),
        .LD        (pc_ld),
        .INC       (pc_inc),
        .SEL       (pc_sel),
        .DIN_IMMED (bus.FROM_IMMED),
        .DIN_STACK (bus.FROM_STACK),
        .PC        (pc),
        .PC_NEXT   (pc_next)
    );

    assign bus.ADDR     = pc;
    assign bus.PC_COUNT = pc;
    assign bus.RET_ADDR = ret_addr;
    assign bus.STATE    = state;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed test-plan steps then random traffic vs. a cycle model.
module tb_pc_fetch_ctrl;
    import rat_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    pc_fetch_ctrl_if bus ();

    pc_fetch_ctrl dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: phase 0=INIT 1=FETCH 2=EXEC 3=INTR
    int         m_phase = 0;
    int         m_pc    = 0;
    bit         m_pend  = 1'b0;
    int         m_ret   = 0;
    logic [9:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic state_t phase_to_state(input int ph);
        case (ph)
            0:       return ST_INIT;
            1:       return ST_FETCH;
            2:       return ST_EXEC;
            default: return ST_INTR;
        endcase
    endfunction

    task automatic check_cycle();
        chk("state", 32'(bus.STATE), 32'(phase_to_state(m_phase)));
        chk("addr", 32'(bus.ADDR), 32'(m_pc));
        chk("pc_count", 32'(bus.PC_COUNT), 32'(m_pc));
        chk("ir_valid", 32'(bus.IR_VALID), 32'(m_phase == 2));
        chk("intr_ack", 32'(bus.INTR_ACK), 32'(m_phase == 3));
        chk("ret_addr_reg", 32'(bus.RET_ADDR), 32'(m_ret));
        if (bus.INTR_ACK === 1'b1) begin
            if (exp_q.size() > 0) chk("ret_q", 32'(bus.RET_ADDR), 32'(exp_q.pop_front()));
            else chk("unexpected_ack", 32'(bus.INTR_ACK), 32'd0);
        end
    endtask

    // Advance one clock: model consumes the inputs applied this cycle.
    task automatic step();
        int  n_phase = m_phase;
        int  n_pc    = m_pc;
        bit  n_pend  = m_pend;
        int  tgt;
        bit  take;
        if (RST) begin
            n_phase = 0; n_pc = 0; n_pend = 1'b0; m_ret = 0;
        end else begin
            case (m_phase)
                0: begin n_phase = 1; n_pend = m_pend | bus.INTR; end
                1: begin n_phase = 2; n_pc = (m_pc + 1) % 1024; n_pend = m_pend | bus.INTR; end
                2: begin
                    tgt = m_pc;
                    if (bus.PC_LD) begin
                        if (bus.PC_MUX_SEL == 2'd0) tgt = int'(bus.FROM_IMMED);
                        else if (bus.PC_MUX_SEL == 2'd1) tgt = int'(bus.FROM_STACK);
                        else if (bus.PC_MUX_SEL == 2'd2) tgt = 1023;
                    end
                    take = (m_pend | bus.INTR) & bus.INT_EN;
                    n_pc = tgt;
                    if (take) begin
                        n_phase = 3; n_pend = 1'b0; m_ret = tgt;
                        exp_q.push_back(10'(tgt));
                    end else begin
                        n_phase = 1; n_pend = m_pend | bus.INTR;
                    end
                end
                default: begin n_phase = 1; n_pc = 1023; n_pend = 1'b0; end
            endcase
        end
        @(posedge CLK);
        m_phase = n_phase; m_pc = n_pc; m_pend = n_pend;
        @(negedge CLK);
        check_cycle();
    endtask

    task automatic goto_exec();
        int budget = 8;
        while (m_phase != 2 && budget > 0) begin
            step();
            budget--;
        end
        chk("goto_exec_timeout", 32'(bus.STATE), 32'(ST_EXEC));
    endtask

    task automatic set_load(input bit ld, input logic [1:0] sel, input logic [9:0] imm, input logic [9:0] stk);
        bus.PC_LD = ld; bus.PC_MUX_SEL = sel; bus.FROM_IMMED = imm; bus.FROM_STACK = stk;
    endtask

    initial begin
        set_load(1'b0, 2'd0, 10'h0, 10'h0);
        bus.INTR = 1'b0;
        bus.INT_EN = 1'b0;
        RST = 1'b1;
        @(negedge CLK);

        // Reset state
        step();
        step();
        chk("reset_state", 32'(bus.STATE), 32'(ST_INIT));
        chk("reset_pc", 32'(bus.ADDR), 32'h0);

        // Free run
        RST = 1'b0;
        step();
        chk("run_fetch0", 32'(bus.ADDR), 32'h0);
        step();
        step();
        chk("run_fetch1", 32'(bus.ADDR), 32'h1);
        step();
        step();
        step();

        // Branch via FROM_IMMED
        goto_exec();
        set_load(1'b1, PCSEL_IMMED, 10'h0A5, 10'h0);
        step();
        set_load(1'b0, 2'd0, 10'h0, 10'h0);
        chk("br_fetch", 32'(bus.ADDR), 32'h0A5);
        step();
        step();
        chk("br_fetch_next", 32'(bus.ADDR), 32'h0A6);

        // Load INTR_VEC then wrap; reserved select holds
        goto_exec();
        set_load(1'b1, PCSEL_INTR, 10'h0, 10'h0);
        step();
        set_load(1'b0, 2'd0, 10'h0, 10'h0);
        chk("vec_fetch", 32'(bus.ADDR), 32'h3FF);
        step();
        chk("wrap", 32'(bus.PC_COUNT), 32'h0);
        set_load(1'b1, 2'd3, 10'h123, 10'h321);
        step();
        set_load(1'b0, 2'd0, 10'h0, 10'h0);
        chk("sel3_hold", 32'(bus.ADDR), 32'h0);

        // Masked interrupt pulse, enabled two instructions later
        bus.INTR = 1'b1;
        step();
        bus.INTR = 1'b0;
        step(); step(); step();
        bus.INT_EN = 1'b1;
        step();
        step();
        chk("masked_ack", 32'(bus.INTR_ACK), 32'h1);
        chk("masked_ret", 32'(bus.RET_ADDR), 32'h3);
        step();
        chk("masked_vec", 32'(bus.ADDR), 32'h3FF);
        chk("masked_ack_off", 32'(bus.INTR_ACK), 32'h0);

        // Interrupt together with a return-from-stack branch
        goto_exec();
        set_load(1'b1, PCSEL_STACK, 10'h0, 10'h040);
        bus.INTR = 1'b1;
        step();
        set_load(1'b0, 2'd0, 10'h0, 10'h0);
        bus.INTR = 1'b0;
        chk("br_intr_ret", 32'(bus.RET_ADDR), 32'h040);
        step();
        chk("br_intr_vec", 32'(bus.ADDR), 32'h3FF);

        // Reset during EXEC with a load and a pending request
        bus.INT_EN = 1'b0;
        bus.INTR = 1'b1;
        step();
        bus.INTR = 1'b0;
        chk("rst_in_exec", 32'(bus.STATE), 32'(ST_EXEC));
        set_load(1'b1, PCSEL_IMMED, 10'h155, 10'h0);
        RST = 1'b1;
        step();
        RST = 1'b0;
        set_load(1'b0, 2'd0, 10'h0, 10'h0);
        chk("rst_state", 32'(bus.STATE), 32'(ST_INIT));
        chk("rst_pc", 32'(bus.ADDR), 32'h0);
        bus.INT_EN = 1'b1;
        repeat (8) step();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            RST        = ($urandom_range(0, 59) == 0);
            bus.INTR   = ($urandom_range(0, 9) == 0);
            bus.INT_EN = ($urandom_range(0, 3) != 0);
            set_load(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                     10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
            step();
        end
        RST = 1'b0;
        bus.INTR = 1'b0;
        set_load(1'b0, 2'd0, 10'h0, 10'h0);
        repeat (4) step();
        chk("ret_q_drain", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
